// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the zero-run detector: MSB-first, DIV cycles per bit, idles high.
// Optional even-parity trailer bit when SER_PARITY_EN is defined.
module serial_bit_feeder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             bit_strobe,
  output logic             busy
);

  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam int unsigned DW = $clog2(DIV + 1);
  localparam logic [BW-1:0] WidthMax = BW'(WIDTH);
  localparam logic [DW-1:0] DivMax   = DW'(DIV);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StShift  = 2'd1;
`ifdef SER_PARITY_EN
  localparam logic [1:0] StParity = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             ser_q, ser_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  assign load_ready = (state_q == StIdle);
  assign ser_out    = ser_q;
  assign bit_strobe = strobe_q;
  assign busy       = busy_q;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bcnt_d   = bcnt_q;
    dcnt_d   = dcnt_q;
    ser_d    = ser_q;
    strobe_d = 1'b0;
    busy_d   = busy_q;
`ifdef SER_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        ser_d  = 1'b1;
        busy_d = 1'b0;
        if (load_valid) begin
          sr_d     = {load_data[WIDTH-2:0], 1'b0};
          ser_d    = load_data[WIDTH-1];
          strobe_d = 1'b1;
          busy_d   = 1'b1;
          bcnt_d   = BW'(1);
          dcnt_d   = DW'(1);
`ifdef SER_PARITY_EN
          par_d    = load_data[WIDTH-1];
`endif
          state_d  = StShift;
        end
      end
      StShift: begin
        if (dcnt_q < DivMax) begin
          dcnt_d = dcnt_q + DW'(1);
        end else if (bcnt_q < WidthMax) begin
          ser_d    = sr_q[WIDTH-1];
          sr_d     = {sr_q[WIDTH-2:0], 1'b0};
          bcnt_d   = bcnt_q + BW'(1);
          dcnt_d   = DW'(1);
          strobe_d = 1'b1;
`ifdef SER_PARITY_EN
          par_d    = par_q ^ sr_q[WIDTH-1];
`endif
        end else begin
`ifdef SER_PARITY_EN
          ser_d    = par_q;
          strobe_d = 1'b1;
          dcnt_d   = DW'(1);
          state_d  = StParity;
`else
          ser_d    = 1'b1;
          busy_d   = 1'b0;
          state_d  = StIdle;
`endif
        end
      end
`ifdef SER_PARITY_EN
      StParity: begin
        if (dcnt_q < DivMax) begin
          dcnt_d = dcnt_q + DW'(1);
        end else begin
          ser_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
`endif
      default: begin
        // Illegal encoding: fall back to idle outputs.
        ser_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      sr_q     <= '0;
      bcnt_q   <= '0;
      dcnt_q   <= '0;
      ser_q    <= 1'b1;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bcnt_q   <= bcnt_d;
      dcnt_q   <= dcnt_d;
      ser_q    <= ser_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
`ifdef SER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: DIV=4 instance for framing/backpressure/reset, DIV=1 for
// the zero-run feed. Honours SER_PARITY_EN for the trailer bit.
module tb_serial_bit_feeder;

`ifdef SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int W = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic       a_valid = 1'b0;
  logic       a_ready, a_ser, a_strobe, a_busy;
  logic [7:0] b_data = 8'h00;
  logic       b_valid = 1'b0;
  logic       b_ready, b_ser, b_strobe, b_busy;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(W), .DIV(D)) u_a (
    .clk(clk), .reset(reset), .load_data(a_data), .load_valid(a_valid),
    .load_ready(a_ready), .ser_out(a_ser), .bit_strobe(a_strobe), .busy(a_busy)
  );

  serial_bit_feeder #(.WIDTH(W), .DIV(1)) u_b (
    .clk(clk), .reset(reset), .load_data(b_data), .load_valid(b_valid),
    .load_ready(b_ready), .ser_out(b_ser), .bit_strobe(b_strobe), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one step after the accepting edge; checks {ser,strobe,busy,ready} each cycle of the
  // word and the idle cycle after it. If hold_k >= 0, offers 8'h3C from cycle hold_k onward.
  task automatic expect_word(input logic [7:0] w, input int hold_k, input string tag);
    logic b;
    int   idx;
    for (int k = 0; k < (W + PAR) * D; k++) begin
      idx = k / D;
      b = (idx < W) ? w[W-1-idx] : ^w;
      check(tag, {a_ser, a_strobe, a_busy, a_ready}, {b, (k % D) == 0, 1'b1, 1'b0});
      if (hold_k >= 0 && k == hold_k) begin
        a_valid = 1'b1;
        a_data  = 8'h3C;
      end
      step();
    end
    check({tag, "_end"}, {a_ser, a_strobe, a_busy, a_ready}, 4'b1001);
  endtask

  initial begin
    #12;
    check("reset_hold", {a_ser, a_strobe, a_busy, a_ready}, 4'b1001);
    step();
    reset = 1'b1;
    step();
    check("post_reset_idle", {a_ser, a_strobe, a_busy, a_ready}, 4'b1001);
    check("b_idle", {b_ser, b_strobe, b_busy, b_ready}, 4'b1001);

    // Basic A5 serialization.
    a_data = 8'hA5; a_valid = 1'b1;
    step();
    a_valid = 1'b0; a_data = 8'h00;
    expect_word(8'hA5, -1, "a5");
    step();
    check("a5_idle2", {a_ser, a_strobe, a_busy, a_ready}, 4'b1001);

    // Backpressure: 3C offered mid-word, accepted on the single idle cycle.
    a_data = 8'hA5; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    expect_word(8'hA5, 2, "bp_a5");
    step();
    a_valid = 1'b0;
    expect_word(8'h3C, -1, "bp_3c");

    // Parity vectors (plain words when parity is disabled).
    a_data = 8'h07; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    expect_word(8'h07, -1, "w07");
    step();
    a_data = 8'h03; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    expect_word(8'h03, -1, "w03");

    // Abort FF after 3 bits, asynchronous reset mid-cycle.
    step();
    a_data = 8'hFF; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    for (int k = 0; k < 3 * D; k++) begin
      check("ff_pre", {a_ser, a_busy}, 2'b11);
      step();
    end
    #2;
    reset = 1'b0;
    #1;
    check("abort_async", {a_ser, a_strobe, a_busy, a_ready}, 4'b1001);
    step();
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("abort_quiet", {a_ser, a_strobe, a_busy, a_ready}, 4'b1001);
    end

    // Reset released with valid already high: accepted on the first edge after release.
    reset = 1'b0;
    a_data = 8'h81; a_valid = 1'b1;
    step();
    reset = 1'b1;
    step();
    a_valid = 1'b0;
    expect_word(8'h81, -1, "w81");

    // Zero-run feed on the DIV=1 instance.
    step();
    b_data = 8'h00; b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    for (int k = 0; k < W + PAR; k++) begin
      check("zero_run", {b_ser, b_strobe, b_busy, b_ready}, 4'b0110);
      step();
    end
    check("zero_run_end", {b_ser, b_strobe, b_busy, b_ready}, 4'b1001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Parallel-to-serial front end that feeds the zero-run sequence detector. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB first on `ser_out`, holding each bit for DIV clock cycles. `bit_strobe` marks the first cycle of each new bit. `ser_out` idles high, so idle periods never register as zeros downstream.

## Interface
- WIDTH, 8: bits per word; must be ≥ 2.
- DIV, 4: clock cycles each bit is held; must be ≥ 1.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_data  input  WIDTH  word to serialize; sampled only on an accepted handshake.
- load_valid  input  1  upstream offers `load_data`.
- load_ready  output  1  block can accept a word; equals 1 exactly when state is IDLE.
- ser_out  output  1  registered serial bit; 1 when idle.
- bit_strobe  output  1  registered one-cycle pulse on the first cycle of each emitted bit.
- busy  output  1  registered; 1 while a word (and parity bit, if enabled) is being emitted.

## Operation
- States: IDLE, SHIFT, and PARITY (PARITY exists only with the macro defined). Encoding is implementer's choice.
- Internal registers:
  - shift register `sr[WIDTH-1:0]`
  - bit counter `bcnt`, $clog2(WIDTH+1) bits
  - divider counter `dcnt`, $clog2(DIV+1) bits
  - parity accumulator `par`, 1 bit, present only with the macro
- IDLE:
  - Conditions: `load_ready` = 1, `ser_out` = 1, `busy` = 0, `bit_strobe` = 0.
  - Accept: on `load_valid` & `load_ready` at a clock edge:
    - `sr` <- `load_data` shifted left by 1.
    - `ser_out` <- `load_data[WIDTH-1]`.
    - `bit_strobe` <- 1, `busy` <- 1.
    - `bcnt` <- 1, `dcnt` <- 1.
    - `par` <- `load_data[WIDTH-1]`.
    - Go to SHIFT.
- SHIFT, when `dcnt` < DIV:
  - `dcnt` increments.
  - `ser_out` holds.
  - `bit_strobe` <- 0.
- SHIFT, when `dcnt` == DIV and `bcnt` < WIDTH:
  - `ser_out` <- `sr[WIDTH-1]`.
  - `sr` shifts left, zero-filled.
  - `bcnt` increments, `dcnt` <- 1.
  - `bit_strobe` <- 1.
  - `par` ^= new bit.
- SHIFT, when `dcnt` == DIV and `bcnt` == WIDTH:
  - Without the macro: go to IDLE. `ser_out` <- 1, `busy` <- 0, `bit_strobe` <- 0.
  - With the macro: go to PARITY. `ser_out` <- `par`, `bit_strobe` <- 1, `dcnt` <- 1.
- PARITY: holds `ser_out` for DIV cycles, then goes to IDLE with the same outputs as the non-macro exit.
- `load_valid` outside IDLE is ignored and has no side effect. Upstream holds its word until `load_ready`.
- Arithmetic: counters are unsigned and never wrap in legal operation. Any illegal state value recovers to IDLE with idle outputs on the next edge.
- DIV = 1: each bit lasts one cycle, and `bit_strobe` stays high for WIDTH consecutive cycles.

## Timing
- Reset asserted (`reset` = 0):
  - Takes effect immediately, regardless of `clk`.
  - State = IDLE, `ser_out` = 1, `bit_strobe` = 0, `busy` = 0, `load_ready` = 1, `sr`/`bcnt`/`dcnt`/`par` = 0.
  - A reset in the middle of a word aborts it; no partial bits follow.
- Accept-to-first-bit latency: 1 cycle. The first bit is visible on the cycle after the accepting edge.
- Word duration: `busy` = 1 for WIDTH×DIV cycles, or (WIDTH+1)×DIV with the macro.
- Back-to-back: `load_ready` returns in the cycle after the last bit ends. The earliest next accept is that same cycle, giving exactly one idle cycle with `ser_out` = 1 between words.
- Reset released while `load_valid` = 1: the word is accepted on the first clock edge after release.

## Configuration
- SER_PARITY_EN defined:
  - Adds the PARITY state.
  - After the data bits, appends one even-parity bit (XOR of all WIDTH data bits) for DIV cycles, with its own `bit_strobe`.
- SER_PARITY_EN undefined:
  - No PARITY state and no `par` register.
  - The word ends after WIDTH bits.

## Test plan
- Reset check: hold `reset` = 0 mid-word with DIV = 4 -> immediately `ser_out` = 1, `busy` = 0, `bit_strobe` = 0, `load_ready` = 1. After release, with no load, `ser_out` stays 1 indefinitely.
- Basic serialization: WIDTH = 8, DIV = 4, load 8'hA5 -> `ser_out` sequence 1,0,1,0,0,1,0,1, each held 4 cycles. `bit_strobe` pulses 8 times, 4 cycles apart. `busy` is high for 32 cycles, then `ser_out` = 1.
- Backpressure: assert `load_valid` with 8'h3C while busy -> no acceptance and no change in output. The word is accepted on the cycle `load_ready` rises, and exactly one idle cycle separates the two words.
- Zero run feed: load 8'h00 with DIV = 1 -> `ser_out` = 0 for 8 consecutive cycles and `bit_strobe` high for 8 consecutive cycles. The downstream detector sees 6 qualifying cycles.
- Parity, with SER_PARITY_EN defined: load 8'h07 -> a 9th bit of 1 appears after the data bits and `busy` lasts 36 cycles at DIV = 4. Loading 8'h03 gives a 9th bit of 0.
- Abort and recover: assert reset after 3 bits of 8'hFF, release, then load 8'h81 -> the output is a clean 1,0,0,0,0,0,0,1 with no residual bits from 8'hFF.
